// File: rtl/crop_word_packer.sv
// ============================================================================
// crop_word_packer : packs the crop pixel stream into little-endian words
// Rev 1.0
// ============================================================================
`default_nettype none

module crop_word_packer #(
  parameter int OUT_ROWS        = 20,
  parameter int OUT_COLS        = 20,
  parameter int NUM_CROPS       = 3,
  parameter int PIXELS_PER_WORD = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [7:0]                   s_axis_tdata,
  input  logic [2:0]                   s_crop_idx,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [8*PIXELS_PER_WORD-1:0] m_axis_tdata,
  output logic [PIXELS_PER_WORD-1:0]   m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic [2:0]                   m_axis_tuser,
  output logic                         m_frame_last,
  output logic                         idx_err
);

  localparam int CROP_PIX = OUT_ROWS * OUT_COLS;
  localparam int PCW      = (CROP_PIX > 1) ? $clog2(CROP_PIX) : 1;
  localparam int LW       = $clog2(PIXELS_PER_WORD);
  localparam int DW       = 8 * PIXELS_PER_WORD;

  localparam logic [PCW-1:0] c_last_pix  = PCW'(CROP_PIX - 1);
  localparam logic [LW-1:0]  c_last_lane = LW'(PIXELS_PER_WORD - 1);
  localparam logic [2:0]     c_last_crop = 3'(NUM_CROPS - 1);

  logic [LW-1:0]              r_lane;
  logic [PCW-1:0]             r_pix_cnt;
  logic [2:0]                 r_crop_cnt;
  logic [DW-1:0]              r_acc_data;
  logic [PIXELS_PER_WORD-1:0] r_acc_keep;

  logic                       w_last_pix;
  logic                       w_completing;
  logic                       w_pix_hs;
  logic [DW-1:0]              w_word_data;
  logic [PIXELS_PER_WORD-1:0] w_word_keep;

  assign w_last_pix   = (r_pix_cnt == c_last_pix);
  assign w_completing = w_last_pix || (r_lane == c_last_lane);

  // Only the word-completing pixel needs room in the output register.
  assign s_axis_tready = !w_completing || !m_axis_tvalid || m_axis_tready;
  assign w_pix_hs      = s_axis_tvalid && s_axis_tready;

  always_comb begin
    w_word_data                 = r_acc_data;
    w_word_keep                 = r_acc_keep;
    w_word_data[8*r_lane +: 8]  = s_axis_tdata;
    w_word_keep[r_lane]         = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lane        <= '0;
      r_pix_cnt     <= '0;
      r_crop_cnt    <= '0;
      r_acc_data    <= '0;
      r_acc_keep    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      m_frame_last  <= 1'b0;
      idx_err       <= 1'b0;
    end else begin
      if (w_pix_hs) begin
        if (w_completing) begin
          r_acc_data <= '0;
          r_acc_keep <= '0;
          r_lane     <= '0;
        end else begin
          r_acc_data <= w_word_data;
          r_acc_keep <= w_word_keep;
          r_lane     <= r_lane + LW'(1);
        end

        if (w_last_pix) begin
          r_pix_cnt  <= '0;
          r_crop_cnt <= (r_crop_cnt == c_last_crop) ? 3'd0 : r_crop_cnt + 3'd1;
        end else begin
          r_pix_cnt  <= r_pix_cnt + PCW'(1);
        end

        if ((r_pix_cnt == '0) && (s_crop_idx != r_crop_cnt))
          idx_err <= 1'b1;
      end

      // A completion reloads the output register even while it drains.
      if (w_pix_hs && w_completing) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= w_word_data;
        m_axis_tkeep  <= w_word_keep;
        m_axis_tlast  <= w_last_pix;
        m_axis_tuser  <= r_crop_cnt;
        m_frame_last  <= w_last_pix && (r_crop_cnt == c_last_crop);
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/crop_word_packer.md
Name: crop_word_packer

Overview:
- Sits directly downstream of the crop sequentializer. Consumes its single 8-bit pixel stream, one crop at a time, together with its crop index.
- Packs pixels little-endian into PIXELS_PER_WORD-wide words for the DMA/host-output path.
- Marks each word with crop index, byte-keep, end-of-crop (tlast) and end-of-frame (last crop of the set).
- Sustains one pixel per cycle. Checks crop ordering against its own counter.

Parameters:
OUT_ROWS, 20, rows per crop
OUT_COLS, 20, columns per crop
NUM_CROPS, 3, crops per frame set (1..8)
PIXELS_PER_WORD, 8, pixels per output word (power of 2, 2..16)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
s_axis_tvalid  in  1  pixel valid from sequentializer
s_axis_tready  out  1  pixel accept
s_axis_tdata  in  8  pixel
s_crop_idx  in  3  crop index driven alongside the pixel stream
m_axis_tvalid  out  1  word valid
m_axis_tready  in  1  downstream accept
m_axis_tdata  out  8*PIXELS_PER_WORD  packed word, first pixel in bits [7:0]
m_axis_tkeep  out  PIXELS_PER_WORD  one bit per valid pixel lane
m_axis_tlast  out  1  last word of a crop
m_axis_tuser  out  3  crop index of this word
m_frame_last  out  1  last word of crop NUM_CROPS-1
idx_err  out  1  sticky crop-order error

Behaviour:
- Reset is asynchronous and active-high, applied on assertion. Synchronous deassertion is handled externally.
- Reset values:
  - m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_frame_last and idx_err are 0.
  - Internal lane, pix_cnt and crop_cnt are 0. The accumulator is cleared.
- Reset mid-operation discards any partial word and any pending output word. No output is flushed.
- CROP_PIX = OUT_ROWS*OUT_COLS. Size pix_cnt as $clog2(CROP_PIX) bits and crop_cnt as 3 bits.
- Pixel handshake is s_axis_tvalid && s_axis_tready. On each handshake:
  - Write the pixel into lane `lane`, bits [8*lane+7 : 8*lane], and set the matching keep bit.
  - Advance pix_cnt and lane.
- A word completes on the handshake where lane == PIXELS_PER_WORD-1 or pix_cnt == CROP_PIX-1.
- On completion the accumulator transfers to the output register in the same clock edge:
  - tdata/tkeep, tuser = crop_cnt, tlast = (pix_cnt == CROP_PIX-1), m_frame_last = tlast && (crop_cnt == NUM_CROPS-1).
  - m_axis_tvalid is set.
  - The accumulator and lane clear. Unused lanes of a partial last word are 0 with keep bit 0.
- Latency: a word is visible on m_axis one cycle after its completing pixel handshake.
- s_axis_tready is combinational: = !(completing_lane) || !m_axis_tvalid || m_axis_tready, where completing_lane is true when the next pixel would complete a word.
  - Non-completing pixels are always accepted.
  - The completing pixel is accepted only if the output register is empty or drains this cycle.
  - Result: full throughput with no bubbles when m_axis_tready stays high.
- Output handshake m_axis_tvalid && m_axis_tready with no new completion: m_axis_tvalid clears. With a simultaneous completion: the register reloads and tvalid stays 1.
- m_axis outputs hold stable while tvalid && !tready.
- End-of-crop wrap:
  - pix_cnt wraps CROP_PIX-1 to 0 and lane restarts at 0, so words never straddle crops.
  - crop_cnt increments and wraps NUM_CROPS-1 to 0.
- idx_err:
  - On the first pixel of each crop (pix_cnt == 0 handshake), if s_crop_idx != crop_cnt, set idx_err.
  - The flag is sticky until reset. Data flow is not altered.

Test Plan:
- Defaults, 3 crops × 400 px, m_axis_tready=1, continuous valid -> 150 words. Every 50th word has tlast. Word 150 has m_frame_last=1. tuser goes 0,1,2. tkeep=0xFF throughout. s_axis_tready never drops.
- Pixel values 0..7 first crop -> first m_axis_tdata = 0x0706050403020100, appearing one cycle after pixel 7 is accepted.
- OUT_ROWS=3, OUT_COLS=3, PIXELS_PER_WORD=4, pixels 1..9 -> words 0x04030201 keep 0xF, 0x08070605 keep 0xF, 0x00000009 keep 0x1 with tlast=1.
- m_axis_tready low for 10 cycles mid-crop:
  - Required: s_axis_tready drops only on a completing pixel and outputs stay stable.
  - Required: after release, no pixel is lost or duplicated and the order is exact.
- s_crop_idx held at 0 throughout -> idx_err rises on the first pixel of crop 1 and stays 1 until reset.
- Assert reset with 5 pixels of a word accumulated and an output word pending -> all outputs 0 immediately. The next 8 pixels form a fresh word with tuser=0.
